masked_subbytes_seq: RTL and testbench

//  Sequencer wrapped around the 2-share masked AES sbox. Accepts one 128-bit
//  AES state as two Boolean shares, streams its 16 bytes share-wise into the

---
 rtl/masked_subbytes_seq.sv | 148 ++++++++++++++
 tb/tb_masked_subbytes_seq.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/masked_subbytes_seq.sv
// Byte-serial sequencer around a 2-share pipelined masked AES sbox.
// Shares are kept in separate registers throughout and are never recombined.
module masked_subbytes_seq #(
    parameter int unsigned SBOX_LAT = 4,
    parameter int unsigned NBYTES   = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_s0,
    input  logic [8*NBYTES-1:0]   in_s1,
    output logic [7:0]            sb_t0,
    output logic [7:0]            sb_t1,
    input  logic [7:0]            sb_y0,
    input  logic [7:0]            sb_y1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_s0,
    output logic [8*NBYTES-1:0]   out_s1,
    output logic                  busy
);

    localparam int unsigned W  = 8 * NBYTES;
    localparam int unsigned IW = $clog2(NBYTES);
    localparam int unsigned CW = IW + 1;

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    state_e                       state_q, state_d;
    logic [W-1:0]                 s0_q, s0_d, s1_q, s1_d;
    logic [W-1:0]                 acc0_q, acc0_d, acc1_q, acc1_d;
    logic [IW-1:0]                icnt_q, icnt_d;
    logic [CW-1:0]                ccnt_q, ccnt_d;
    logic [7:0]                   t0_q, t0_d, t1_q, t1_d;
    logic [SBOX_LAT-1:0]          tag_vld_q, tag_vld_d;
    logic [SBOX_LAT-1:0][IW-1:0]  tag_idx_q, tag_idx_d;
    logic                         out_valid_q, out_valid_d;
    logic                         issue;

    always_comb begin
        state_d     = state_q;
        s0_d        = s0_q;
        s1_d        = s1_q;
        acc0_d      = acc0_q;
        acc1_d      = acc1_q;
        icnt_d      = icnt_q;
        ccnt_d      = ccnt_q;
        t0_d        = '0;
        t1_d        = '0;
        out_valid_d = out_valid_q;
        issue       = 1'b0;
        tag_vld_d   = '0;
        tag_idx_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    s0_d    = in_s0;
                    s1_d    = in_s1;
                    icnt_d  = '0;
                    ccnt_d  = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                issue  = 1'b1;
                t0_d   = s0_q[{icnt_q, 3'b000} +: 8];
                t1_d   = s1_q[{icnt_q, 3'b000} +: 8];
                icnt_d = icnt_q + 1'b1;
                if (icnt_q == IW'(NBYTES - 1)) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (ccnt_q == CW'(NBYTES)) begin
                    state_d     = StDone;
                    out_valid_d = 1'b1;
                    s0_d        = '0;
                    s1_d        = '0;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    acc0_d      = '0;
                    acc1_d      = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Tag line mirrors the sbox pipeline so the tail marks which byte is on sb_y*.
        tag_vld_d[0] = issue;
        tag_idx_d[0] = icnt_q;
        for (int j = 1; j < SBOX_LAT; j++) begin
            tag_vld_d[j] = tag_vld_q[j-1];
            tag_idx_d[j] = tag_idx_q[j-1];
        end

        if (tag_vld_q[SBOX_LAT-1]) begin
            acc0_d[{tag_idx_q[SBOX_LAT-1], 3'b000} +: 8] = sb_y0;
            acc1_d[{tag_idx_q[SBOX_LAT-1], 3'b000} +: 8] = sb_y1;
            ccnt_d = ccnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            s0_q        <= '0;
            s1_q        <= '0;
            acc0_q      <= '0;
            acc1_q      <= '0;
            icnt_q      <= '0;
            ccnt_q      <= '0;
            t0_q        <= '0;
            t1_q        <= '0;
            tag_vld_q   <= '0;
            tag_idx_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s0_q        <= s0_d;
            s1_q        <= s1_d;
            acc0_q      <= acc0_d;
            acc1_q      <= acc1_d;
            icnt_q      <= icnt_d;
            ccnt_q      <= ccnt_d;
            t0_q        <= t0_d;
            t1_q        <= t1_d;
            tag_vld_q   <= tag_vld_d;
            tag_idx_q   <= tag_idx_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign sb_t0     = t0_q;
    assign sb_t1     = t1_q;
    assign out_valid = out_valid_q;
    // Partially collected shares stay hidden until the full state is valid.
    assign out_s0    = acc0_q & {W{out_valid_q}};
    assign out_s1    = acc1_q & {W{out_valid_q}};

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Directed bench: two instances (sbox latency 4 and 1) fed the same stimulus,
// each paired with a behavioural masked sbox that applies a fresh mask every cycle.
module tb_masked_subbytes_seq;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [127:0] in_s0, in_s1;

    logic         a_in_ready, a_out_valid, a_busy;
    logic [7:0]   a_sb_t0, a_sb_t1, a_sb_y0, a_sb_y1;
    logic [127:0] a_out_s0, a_out_s1;
    logic         b_in_ready, b_out_valid, b_busy;
    logic [7:0]   b_sb_t0, b_sb_t1, b_sb_y0, b_sb_y1;
    logic [127:0] b_out_s0, b_out_s1;

    int n_pass   = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    masked_subbytes_seq #(.SBOX_LAT(LAT_A), .NBYTES(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .sb_t0(a_sb_t0), .sb_t1(a_sb_t1),
        .sb_y0(a_sb_y0), .sb_y1(a_sb_y1), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_s0(a_out_s0), .out_s1(a_out_s1), .busy(a_busy)
    );

    masked_subbytes_seq #(.SBOX_LAT(LAT_B), .NBYTES(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_s0(in_s0), .in_s1(in_s1), .sb_t0(b_sb_t0), .sb_t1(b_sb_t1),
        .sb_y0(b_sb_y0), .sb_y1(b_sb_y1), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_s0(b_out_s0), .out_s1(b_out_s1), .busy(b_busy)
    );

    // Only the AES S-box entries the vectors use; anything else yields a wrong byte.
    function automatic logic [7:0] sbox_fn(input logic [7:0] x);
        case (x)
            8'h00:   sbox_fn = 8'h63;
            8'h01:   sbox_fn = 8'h7C;
            8'h53:   sbox_fn = 8'hED;
            8'hFF:   sbox_fn = 8'h16;
            default: sbox_fn = x ^ 8'hA5;
        endcase
    endfunction

    // ha*[j] holds the sb_t value driven j+1 cycles before the current one.
    logic [7:0] ha0 [8];
    logic [7:0] ha1 [8];
    logic [7:0] mask_a = 8'h00;
    logic [7:0] mask_b = 8'h00;

    always @(posedge clk) begin
        ha0[0] <= a_sb_t0;
        ha1[0] <= a_sb_t1;
        for (int j = 1; j < 8; j++) begin
            ha0[j] <= ha0[j-1];
            ha1[j] <= ha1[j-1];
        end
        mask_a <= 8'($urandom);
        mask_b <= 8'($urandom);
    end

    assign a_sb_y1 = mask_a;
    assign a_sb_y0 = sbox_fn(ha0[LAT_A-2] ^ ha1[LAT_A-2]) ^ mask_a;
    assign b_sb_y1 = mask_b;
    assign b_sb_y0 = sbox_fn(b_sb_t0 ^ b_sb_t1) ^ mask_b;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Accepts one state at E0, follows it to DONE, optionally stalls, then hands it off.
    task automatic do_state(input logic [127:0] a0, input logic [127:0] a1,
                            input logic [127:0] exp, input int hold);
        int first_a;
        int first_b;
        in_s0    = a0;
        in_s1    = a1;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("busy_after_accept", 128'(a_busy), 128'd1);
        chk("in_ready_after_accept", 128'(a_in_ready), 128'd0);
        first_a = -1;
        first_b = -1;
        for (int n = 1; n <= 60 && first_a < 0; n++) begin
            tick();
            if (n == 1) begin
                chk("sb_t0_byte0", 128'(a_sb_t0), 128'(a0[7:0]));
                chk("sb_t1_byte0", 128'(a_sb_t1), 128'(a1[7:0]));
            end
            if (n == 17) begin
                chk("drain_sb_t", {a_sb_t0, a_sb_t1}, 128'd0);
                chk("drain_out_hidden", a_out_s0 | a_out_s1, 128'd0);
            end
            if (b_out_valid && first_b < 0) first_b = n;
            if (a_out_valid) first_a = n;
        end
        chk("latency_a", 128'(first_a), 128'(17 + LAT_A));
        chk("latency_b", 128'(first_b), 128'(17 + LAT_B));
        chk("result_a", a_out_s0 ^ a_out_s1, exp);
        chk("result_b", b_out_s0 ^ b_out_s1, exp);
        if (hold > 0) begin
            in_valid = 1'b1;
            in_s0    = ~a0;
            in_s1    = a1;
            repeat (hold) tick();
            chk("hold_out_valid", 128'(a_out_valid), 128'd1);
            chk("hold_in_ready", 128'(a_in_ready), 128'd0);
            chk("hold_result_a", a_out_s0 ^ a_out_s1, exp);
            chk("hold_result_b", b_out_s0 ^ b_out_s1, exp);
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("handoff_out_valid", 128'({a_out_valid, b_out_valid}), 128'd0);
        chk("handoff_out_s", a_out_s0 | a_out_s1, 128'd0);
        chk("handoff_idle", 128'({a_in_ready, a_busy}), 128'b10);
    endtask

    logic [127:0] u, m, e;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_s0     = '0;
        in_s1     = '0;
        repeat (3) tick();
        chk("rst_sb_t", {a_sb_t0, a_sb_t1, b_sb_t0, b_sb_t1}, 128'd0);
        chk("rst_out_valid", 128'({a_out_valid, b_out_valid}), 128'd0);
        chk("rst_busy", 128'({a_busy, b_busy}), 128'd0);
        chk("rst_out_s", a_out_s0 | a_out_s1, 128'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 128'({a_in_ready, b_in_ready}), 128'b11);
        tick();

        // All-zero shares.
        do_state(128'd0, 128'd0, {16{8'h63}}, 0);

        // Repeating 00 01 53 FF pattern under a fixed random-looking mask.
        u = {4{32'h0001_53FF}};
        m = 128'h3C1F_A97E_0B62_D4C5_88E1_7F20_9A4D_1736;
        do_state(u ^ m, m, {4{32'h637C_ED16}}, 0);

        // Stall in DONE for 10 cycles with a competing input offered.
        u = {16{8'h53}};
        m = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;
        do_state(u ^ m, m, {16{8'hED}}, 10);

        // Reset while icnt==7.
        u = {16{8'h01}};
        m = 128'h5A5A_1234_9876_FEDC_0F0F_7777_3141_5926;
        in_s0    = u ^ m;
        in_s1    = m;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (7) tick();
        chk("mid_sb_t0_byte6", 128'(a_sb_t0), 128'(8'h01 ^ m[55:48]));
        rst_n = 1'b0;
        #1;
        chk("midrst_sb_t", {a_sb_t0, a_sb_t1, b_sb_t0, b_sb_t1}, 128'd0);
        chk("midrst_flags", 128'({a_busy, a_out_valid, a_in_ready}), 128'b001);
        chk("midrst_out_s", a_out_s0 | a_out_s1, 128'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Mixed byte order to catch indexing errors.
        u = {32'hFF53_0100, 32'h0001_53FF, 32'h5300_FF01, 32'h01FF_0053};
        m = 128'h0123_4567_89AB_CDEF_1357_9BDF_2468_ACE0;
        e = {32'h16ED_7C63, 32'h637C_ED16, 32'hED63_167C, 32'h7C16_63ED};
        do_state(u ^ m, m, e, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
